usb_rw_sequencer: RTL

USB_RW_SEQUENCER -- requirements
Module: usb_rw_sequencer

---
 rtl/usb_rw_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/usb_rw_sequencer.sv
// Read/write transaction sequencer driving a USB protocol FSM: address OUT phase then data IN/OUT phase.
// Optional build macro RW_RETRY_EN: one automatic restart at the address phase on the first cancel.
module usb_rw_sequencer #(
  parameter logic [6:0] DEV_ADDR  = 7'd5,
  parameter logic [3:0] ADDR_ENDP = 4'd4,
  parameter logic [3:0] DATA_ENDP = 4'd8
) (
  input  logic        clk,
  input  logic        rst_L,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [15:0] mem_addr,
  input  logic [63:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        success,
  output logic [63:0] rd_data,
  output logic        send_in,
  output logic        input_ready,
  output logic [63:0] data,
  output logic [6:0]  addr,
  output logic [3:0]  endp,
  output logic        got_result,
  input  logic        free,
  input  logic        cancel,
  input  logic        recv_ready,
  input  logic [63:0] data_recv
);

  typedef enum logic [2:0] {
    IDLE, ADDR_ISSUE, ADDR_WAIT, DATA_ISSUE, DATA_WAIT, FINISH
  } state_t;

  state_t      state;
  logic        op_read;
  logic        last_grant_wr;
  logic        blank;
  logic [15:0] addr_q;
  logic [63:0] wdata_q;
  logic        grant_read;
  logic        cancel_hit;
`ifdef RW_RETRY_EN
  logic        retry;
`endif

  always_comb begin
    grant_read = req_read & (~req_write | last_grant_wr);
  end

  // free/cancel are ignored both in the input_ready cycle and the blank cycle after it
  always_comb begin
    cancel_hit = cancel & ~input_ready & ~blank &
                 ((state == ADDR_WAIT) || (state == DATA_WAIT));
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      success       <= 1'b0;
      send_in       <= 1'b0;
      input_ready   <= 1'b0;
      got_result    <= 1'b0;
      rd_data       <= '0;
      data          <= '0;
      addr          <= '0;
      endp          <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      op_read       <= 1'b0;
      last_grant_wr <= 1'b1;
      blank         <= 1'b0;
`ifdef RW_RETRY_EN
      retry         <= 1'b0;
`endif
    end else begin
      input_ready <= 1'b0;
      got_result  <= 1'b0;
      done        <= 1'b0;
      success     <= 1'b0;
      blank       <= input_ready;
      if (cancel_hit) begin
`ifdef RW_RETRY_EN
        if (!retry) begin
          retry   <= 1'b1;
          send_in <= 1'b0;
          state   <= ADDR_ISSUE;
        end else begin
          send_in <= 1'b0;
          done    <= 1'b1;
          state   <= FINISH;
        end
`else
        send_in <= 1'b0;
        done    <= 1'b1;
        state   <= FINISH;
`endif
      end else begin
        case (state)
          IDLE: begin
`ifdef RW_RETRY_EN
            retry <= 1'b0;
`endif
            if (req_read || req_write) begin
              addr_q        <= mem_addr;
              wdata_q       <= wr_data;
              op_read       <= grant_read;
              last_grant_wr <= ~grant_read;
              busy          <= 1'b1;
              state         <= ADDR_ISSUE;
            end
          end
          ADDR_ISSUE: begin
            if (free) begin
              input_ready <= 1'b1;
              send_in     <= 1'b0;
              addr        <= DEV_ADDR;
              endp        <= ADDR_ENDP;
              data        <= {48'b0, addr_q};
              state       <= ADDR_WAIT;
            end
          end
          ADDR_WAIT: begin
            if (!input_ready && !blank && free) begin
              input_ready <= 1'b1;
              send_in     <= op_read;
              addr        <= DEV_ADDR;
              endp        <= DATA_ENDP;
              if (!op_read) data <= wdata_q;
              state       <= DATA_ISSUE;
            end
          end
          DATA_ISSUE: state <= DATA_WAIT;
          DATA_WAIT: begin
            if (op_read && recv_ready) begin
              rd_data    <= data_recv;
              got_result <= 1'b1;
              send_in    <= 1'b0;
              done       <= 1'b1;
              success    <= 1'b1;
              state      <= FINISH;
            end else if (!op_read && !blank && free) begin
              done    <= 1'b1;
              success <= 1'b1;
              state   <= FINISH;
            end
          end
          FINISH: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
